// File: rtl/regfile_pkg.sv
// Shared definitions for the special register file and its access port:
// sequencer state encoding, register count and register address map.
package regfile_pkg;

    localparam int NUM_REGS = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [3:0] RA = 4'd0;
    localparam logic [3:0] IN = 4'd1;
    localparam logic [3:0] DR = 4'd2;
    localparam logic [3:0] ST = 4'd3;
    localparam logic [3:0] CS = 4'd4;
    localparam logic [3:0] EC = 4'd5;
    localparam logic [3:0] CF = 4'd6;
    localparam logic [3:0] CV = 4'd7;
    localparam logic [3:0] OP = 4'd8;

endpackage

// File: rtl/regfile_port_arbiter_rr_arbiter2.sv
// Two-way round-robin picker. ptr_i names the requester that wins a tie
// (0 = A, 1 = B); after a grant the tie-break moves to the other requester.
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output logic       ptr_o
);

    always_comb begin
        gnt_o = 2'b00;
        ptr_o = ptr_i;
        if (en_i) begin
            if (req_i[0] && (!req_i[1] || !ptr_i)) begin
                gnt_o = 2'b01;
                ptr_o = 1'b1;
            end else if (req_i[1]) begin
                gnt_o = 2'b10;
                ptr_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the single addr/din/we/dout port of the special register file between
// requesters A and B, sequencing each access as IDLE -> SETUP -> ACCESS -> DONE.
module regfile_port_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_din,
    output logic              rf_we,
    input  logic [DATA_W-1:0] rf_dout
);
    import regfile_pkg::*;

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [1:0]        req_v, gnt;
    logic [1:0]        we_v;
    logic [ADDR_W-1:0] addr_v  [2];
    logic [DATA_W-1:0] wdata_v [2];
    logic [DATA_W-1:0] rdata_q [2];
    logic              gnt_b_q, we_q, valid_q;
    logic [ADDR_W-1:0] rf_addr_q, sel_addr;
    logic [DATA_W-1:0] wdata_q, rf_din_q;

    assign req_v      = {b_req, a_req};
    assign we_v       = {b_we, a_we};
    assign addr_v[0]  = a_addr;
    assign addr_v[1]  = b_addr;
    assign wdata_v[0] = a_wdata;
    assign wdata_v[1] = b_wdata;
    assign sel_addr   = addr_v[gnt[1]];

    rr_arbiter2 u_arb (
        .req_i (req_v),
        .ptr_i (ptr_q),
        .en_i  (state_q == IDLE),
        .gnt_o (gnt),
        .ptr_o (ptr_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|gnt) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != IDLE);
        rf_we = (state_q == ACCESS) && we_q && valid_q && !reset;
        err   = (state_q == DONE) && !valid_q;
        a_ack = (state_q == DONE) && !gnt_b_q;
        b_ack = (state_q == DONE) && gnt_b_q;
    end

    // rf_addr is driven from the grant edge so it is stable for the whole
    // SETUP cycle, when the file registers its select and dout.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q     <= 1'b0;
            gnt_b_q   <= 1'b0;
            we_q      <= 1'b0;
            valid_q   <= 1'b0;
            rf_addr_q <= '0;
            wdata_q   <= '0;
            rf_din_q  <= '0;
        end else begin
            if (state_q == IDLE && |gnt) begin
                ptr_q     <= ptr_d;
                gnt_b_q   <= gnt[1];
                we_q      <= we_v[gnt[1]];
                rf_addr_q <= sel_addr;
                wdata_q   <= wdata_v[gnt[1]];
                valid_q   <= int'(sel_addr) < NUM_REGS;
            end
            if (state_q == SETUP) begin
                rf_din_q <= wdata_q;
            end
        end
    end

    assign rf_addr = rf_addr_q;
    assign rf_din  = rf_din_q;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
        always_ff @(posedge clk) begin
            if (reset) begin
                rdata_q[gi] <= '0;
            end else if (state_q == ACCESS && !we_q && gnt_b_q == 1'(gi)) begin
                rdata_q[gi] <= valid_q ? rf_dout : '0;
            end
        end
    end

    assign a_rdata = rdata_q[0];
    assign b_rdata = rdata_q[1];

endmodule
